// File: rtl/rx_rs232.sv
// rx_rs232: UART receiver for the 11-bit frame start, D0..D7 (LSB first),
// fixed '1' bit, stop. Samples at mid-bit, strobes oVALID on a good frame and
// oFERR when the fixed bit or the stop bit is sampled low.
module rx_rs232 #(
  parameter int unsigned CLK_PER_BIT = 5208
) (
  input  logic       clk_s,
  input  logic       rstn_s,
  input  logic       iRX,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFERR,
  output logic       oBUSY
);

  // Start-bit mid-sample offset, derived from the bit period.
  localparam int unsigned HALF_BIT = CLK_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(CLK_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          par_ok_q;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous serial line, preset to idle.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], iRX};
    end
  end

  // Receive FSM; counter is cleared on every state change and after each
  // mid-bit sample, so samples stay one full bit apart.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_ok_q <= 1'b0;
      oDATA    <= '0;
      oVALID   <= 1'b0;
      oFERR    <= 1'b0;
      oBUSY    <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      oFERR  <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
            oBUSY   <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              oBUSY   <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s, shreg_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_q <= S_PAR;
            end
          end
        end
        S_PAR: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            par_ok_q <= rx_s;
            state_q  <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (par_ok_q && rx_s) begin
              oDATA   <= shreg_q;
              oVALID  <= 1'b1;
              oBUSY   <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              oFERR   <= 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= S_IDLE;
            oBUSY   <= 1'b0;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
          oBUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule
